// File: rtl/set_job_arbiter.sv
// Round-robin arbiter sharing one SET circle-counting datapath between two requesters.
// Issues one job at a time with the en/busy handshake and returns the result, or a timeout abort.
module set_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_req,
    input  logic [23:0] r0_central,
    input  logic [11:0] r0_radius,
    input  logic [1:0]  r0_mode,
    output logic        r0_ack,
    output logic        r0_done,
    output logic [7:0]  r0_candidate,
    output logic        r0_err,

    input  logic        r1_req,
    input  logic [23:0] r1_central,
    input  logic [11:0] r1_radius,
    input  logic [1:0]  r1_mode,
    output logic        r1_ack,
    output logic        r1_done,
    output logic [7:0]  r1_candidate,
    output logic        r1_err,

    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW:0] TimeoutVal = (CntW + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q;
    logic            owner_q;      // 1 = job belongs to R1
    logic            prefer_r1_q;  // set after R0 is granted
    logic [CntW-1:0] cnt_q;

    logic            grant_r1;
    logic [CntW:0]   cnt_inc;
    logic            wait_valid;
    logic            wait_timeout;
    logic [7:0]      resp_cand;

    always_comb begin
        grant_r1     = r1_req && (!r0_req || prefer_r1_q);
        cnt_inc      = {1'b0, cnt_q} + (CntW + 1)'(1);
        // The valid seen during the set_en cycle belongs to a previous job.
        wait_valid   = set_valid && !set_en;
        wait_timeout = (cnt_inc >= TimeoutVal);
        resp_cand    = wait_valid ? set_candidate : 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            prefer_r1_q  <= 1'b0;
            cnt_q        <= '0;
            r0_ack       <= 1'b0;
            r0_done      <= 1'b0;
            r0_candidate <= 8'd0;
            r0_err       <= 1'b0;
            r1_ack       <= 1'b0;
            r1_done      <= 1'b0;
            r1_candidate <= 8'd0;
            r1_err       <= 1'b0;
            set_en       <= 1'b0;
            set_central  <= 24'd0;
            set_radius   <= 12'd0;
            set_mode     <= 2'd0;
        end else begin
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            r0_err  <= 1'b0;
            r1_err  <= 1'b0;
            set_en  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (r0_req || r1_req) begin
                        owner_q     <= grant_r1;
                        prefer_r1_q <= !grant_r1;
                        set_central <= grant_r1 ? r1_central : r0_central;
                        set_radius  <= grant_r1 ? r1_radius  : r0_radius;
                        set_mode    <= grant_r1 ? r1_mode    : r0_mode;
                        r0_ack      <= !grant_r1;
                        r1_ack      <= grant_r1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (!set_busy) begin
                        set_en  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_inc[CntW-1:0];
                    end
                    if (wait_valid || wait_timeout) begin
                        state_q <= StResp;
                        if (owner_q) begin
                            r1_done      <= 1'b1;
                            r1_err       <= !wait_valid;
                            r1_candidate <= resp_cand;
                        end else begin
                            r0_done      <= 1'b1;
                            r0_err       <= !wait_valid;
                            r0_candidate <= resp_cand;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_job_arbiter.sv
// Directed bench for set_job_arbiter: requester models, a SET stub and a pulse logger,
// with one task per scenario doing its own comparisons.
`timescale 1ns/1ps
module tb_set_job_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [23:0] r0_central = '0, r1_central = '0;
    logic [11:0] r0_radius = '0, r1_radius = '0;
    logic [1:0]  r0_mode = '0, r1_mode = '0;
    logic        r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err;
    logic [7:0]  r0_candidate, r1_candidate;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy = 1'b0;
    logic        set_valid = 1'b0;
    logic [7:0]  set_candidate = 8'd0;

    set_job_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_central(r0_central), .r0_radius(r0_radius), .r0_mode(r0_mode),
        .r0_ack(r0_ack), .r0_done(r0_done), .r0_candidate(r0_candidate), .r0_err(r0_err),
        .r1_req(r1_req), .r1_central(r1_central), .r1_radius(r1_radius), .r1_mode(r1_mode),
        .r1_ack(r1_ack), .r1_done(r1_done), .r1_candidate(r1_candidate), .r1_err(r1_err),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold req while posted jobs exceed acked jobs.
    int r0_post = 0, r0_taken = 0, r1_post = 0, r1_taken = 0;
    always begin
        @(posedge clk); #1;
        if (r0_ack === 1'b1) r0_taken++;
        r0_req = (r0_post != r0_taken);
    end
    always begin
        @(posedge clk); #1;
        if (r1_ack === 1'b1) r1_taken++;
        r1_req = (r1_post != r1_taken);
    end

    // SET stub: valid stub_k cycles after the en cycle; optional stale valid in the en cycle.
    bit       stub_on = 1'b0, stub_stale = 1'b0, stub_echo = 1'b0;
    int       stub_k = 3;
    logic [7:0] stub_val = 8'd0;
    always begin
        @(posedge clk); #1;
        if (stub_on && set_en === 1'b1) begin
            if (stub_stale) begin set_valid = 1'b1; set_candidate = 8'd99; end
            repeat (stub_k) begin @(posedge clk); #1; set_valid = 1'b0; end
            set_valid = 1'b1;
            set_candidate = stub_echo ? set_radius[7:0] : stub_val;
            @(posedge clk); #1;
            set_valid = 1'b0;
            set_candidate = 8'd0;
        end
    end

    // Pulse logger.
    int         grant_own[$], grant_cyc[$], en_cyc[$], done_own[$], done_cyc[$];
    logic [23:0] en_c[$];
    logic [11:0] en_r[$];
    logic [1:0]  en_m[$];
    logic [7:0]  done_cand[$];
    logic        done_err[$];
    int n_err_stray = 0, n_r1_act = 0;
    always @(negedge clk) begin
        if (r0_ack === 1'b1) begin grant_own.push_back(0); grant_cyc.push_back(cyc); end
        if (r1_ack === 1'b1) begin grant_own.push_back(1); grant_cyc.push_back(cyc); end
        if (set_en === 1'b1) begin
            en_cyc.push_back(cyc);
            en_c.push_back(set_central);
            en_r.push_back(set_radius);
            en_m.push_back(set_mode);
        end
        if (r0_done === 1'b1) begin
            done_own.push_back(0); done_cand.push_back(r0_candidate);
            done_err.push_back(r0_err); done_cyc.push_back(cyc);
        end
        if (r1_done === 1'b1) begin
            done_own.push_back(1); done_cand.push_back(r1_candidate);
            done_err.push_back(r1_err); done_cyc.push_back(cyc);
        end
        if ((r0_err && !r0_done) || (r1_err && !r1_done)) n_err_stray++;
        if (r1_ack || r1_done || r1_err || r1_candidate != 8'd0) n_r1_act++;
    end

    task automatic post_jobs(input int n0, input int n1);
        @(negedge clk);
        r0_post += n0;
        r1_post += n1;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done_own.size() >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err, set_en} !== 7'd0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 0",
                {r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err, set_en});
        end
        n_cmp++;
        if ({r0_candidate, r1_candidate} !== 16'd0) begin
            n_bad++; $display("FAIL reset_cand: got %h want 0", {r0_candidate, r1_candidate});
        end
        n_cmp++;
        if ({set_central, set_radius, set_mode} !== 38'd0) begin
            n_bad++; $display("FAIL reset_payload: got %h want 0",
                {set_central, set_radius, set_mode});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_single_job;
        int nd, ng, ne, na1;
        bit ok;
        nd = done_own.size(); ng = grant_own.size(); ne = en_cyc.size(); na1 = n_r1_act;
        r0_central = 24'h223344; r0_radius = 12'h321; r0_mode = 2'b00;
        stub_on = 1'b1; stub_echo = 1'b0; stub_k = 3; stub_val = 8'd12;
        post_jobs(1, 0);
        wait_done(nd + 1, ok);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", ok); end
        n_cmp++;
        if (grant_own.size() - ng !== 1 || grant_own[ng] !== 0) begin
            n_bad++; $display("FAIL single_ack: got %0d acks owner %0d want 1 owner 0",
                grant_own.size() - ng, grant_own[ng]);
        end
        n_cmp++;
        if (en_cyc.size() - ne !== 1) begin
            n_bad++; $display("FAIL single_en_count: got %0d want 1", en_cyc.size() - ne);
        end
        n_cmp++;
        if ({en_c[ne], en_r[ne], en_m[ne]} !== {24'h223344, 12'h321, 2'b00}) begin
            n_bad++; $display("FAIL single_payload: got %h want %h",
                {en_c[ne], en_r[ne], en_m[ne]}, {24'h223344, 12'h321, 2'b00});
        end
        n_cmp++;
        if (done_own.size() - nd !== 1 || done_own[nd] !== 0) begin
            n_bad++; $display("FAIL single_done_pulse: got %0d dones want 1",
                done_own.size() - nd);
        end
        n_cmp++;
        if (done_cand[nd] !== 8'd12 || done_err[nd] !== 1'b0) begin
            n_bad++; $display("FAIL single_result: got %0d err %b want 12 err 0",
                done_cand[nd], done_err[nd]);
        end
        n_cmp++;
        if (en_cyc[ne] - grant_cyc[ng] !== 1 || done_cyc[nd] - en_cyc[ne] !== 4) begin
            n_bad++; $display("FAIL single_latency: got en+%0d done+%0d want en+1 done+4",
                en_cyc[ne] - grant_cyc[ng], done_cyc[nd] - en_cyc[ne]);
        end
        n_cmp++;
        if (n_r1_act - na1 !== 0) begin
            n_bad++; $display("FAIL single_r1_quiet: got %0d active cycles want 0",
                n_r1_act - na1);
        end
        n_cmp++;
        if (r0_candidate !== 8'd12) begin
            n_bad++; $display("FAIL single_hold: got %0d want 12", r0_candidate);
        end
    endtask

    task automatic test_round_robin;
        int nd, ng, ne;
        bit ok;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        nd = done_own.size(); ng = grant_own.size(); ne = en_cyc.size();
        r0_central = 24'h111111; r0_radius = 12'h0AB; r0_mode = 2'b01;
        r1_central = 24'h999999; r1_radius = 12'h0CD; r1_mode = 2'b10;
        stub_echo = 1'b1; stub_k = 1;
        post_jobs(3, 3);
        wait_done(nd + 6, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_done: got %b want 1", ok); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (grant_own[ng + i] !== (i % 2) || done_own[nd + i] !== (i % 2)) begin
                n_bad++; $display("FAIL rr_order_%0d: got grant %0d done %0d want %0d",
                    i, grant_own[ng + i], done_own[nd + i], i % 2);
            end
            n_cmp++;
            if (done_cand[nd + i] !== ((i % 2) ? 8'hCD : 8'hAB) ||
                en_m[ne + i] !== ((i % 2) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL rr_route_%0d: got cand %h mode %b", i,
                    done_cand[nd + i], en_m[ne + i]);
            end
        end
        n_cmp++;
        if (grant_cyc[ng + 1] - done_cyc[nd] !== 2) begin
            n_bad++; $display("FAIL rr_gap: got %0d want 2", grant_cyc[ng + 1] - done_cyc[nd]);
        end
    endtask

    task automatic test_busy_stall;
        int nd, ne;
        bit ok;
        bit seen;
        nd = done_own.size(); ne = en_cyc.size();
        r0_central = 24'hABCDEF; r0_radius = 12'h456; r0_mode = 2'b11;
        stub_echo = 1'b0; stub_k = 2; stub_val = 8'h5A;
        @(negedge clk) set_busy = 1'b1;
        post_jobs(1, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = r0_ack;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL busy_ack: got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (set_en !== 1'b0 ||
                {set_central, set_radius, set_mode} !== {24'hABCDEF, 12'h456, 2'b11}) begin
                n_bad++; $display("FAIL busy_hold_%0d: got en %b payload %h", i, set_en,
                    {set_central, set_radius, set_mode});
            end
            @(posedge clk); #1;
        end
        set_busy = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (set_en !== 1'b1) begin n_bad++; $display("FAIL busy_en: got %b want 1", set_en); end
        @(posedge clk); #1;
        n_cmp++; if (set_en !== 1'b0) begin n_bad++; $display("FAIL busy_en_once: got %b want 0", set_en); end
        wait_done(nd + 1, ok);
        n_cmp++;
        if (ok !== 1'b1 || done_cand[nd] !== 8'h5A || en_cyc.size() - ne !== 1) begin
            n_bad++; $display("FAIL busy_result: got ok %b cand %h ens %0d want 1 5a 1", ok,
                done_cand[nd], en_cyc.size() - ne);
        end
    endtask

    task automatic test_timeout;
        int nd, ng, ne;
        bit ok;
        nd = done_own.size(); ng = grant_own.size(); ne = en_cyc.size();
        stub_on = 1'b0; stub_echo = 1'b0; stub_k = 2; stub_val = 8'h3C;
        post_jobs(1, 0);
        for (int i = 0; i < 20 && grant_own.size() == ng; i++) @(posedge clk);
        post_jobs(0, 1);
        wait_done(nd + 1, ok);
        stub_on = 1'b1;
        wait_done(nd + 2, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL to_done: got %b want 1", ok); end
        n_cmp++;
        if (done_own[nd] !== 0 || done_err[nd] !== 1'b1 || done_cand[nd] !== 8'd0) begin
            n_bad++; $display("FAIL to_abort: got own %0d err %b cand %0d want 0 1 0",
                done_own[nd], done_err[nd], done_cand[nd]);
        end
        n_cmp++;
        if (done_cyc[nd] - en_cyc[ne] !== 16) begin
            n_bad++; $display("FAIL to_latency: got %0d want 16", done_cyc[nd] - en_cyc[ne]);
        end
        n_cmp++;
        if (grant_own[ng + 1] !== 1 || done_own[nd + 1] !== 1 || done_err[nd + 1] !== 1'b0 ||
            done_cand[nd + 1] !== 8'h3C) begin
            n_bad++; $display("FAIL to_next_r1: got own %0d err %b cand %h want 1 0 3c",
                done_own[nd + 1], done_err[nd + 1], done_cand[nd + 1]);
        end
    endtask

    task automatic test_collision;
        int nd, ne;
        bit ok;
        nd = done_own.size(); ne = en_cyc.size();
        stub_on = 1'b1; stub_stale = 1'b0; stub_echo = 1'b0; stub_k = 15; stub_val = 8'd7;
        post_jobs(1, 0);
        wait_done(nd + 1, ok);
        n_cmp++;
        if (ok !== 1'b1 || done_err[nd] !== 1'b0 || done_cand[nd] !== 8'd7 ||
            done_cyc[nd] - en_cyc[ne] !== 16) begin
            n_bad++; $display("FAIL collide: got err %b cand %0d at +%0d want 0 7 +16",
                done_err[nd], done_cand[nd], done_cyc[nd] - en_cyc[ne]);
        end
        nd = done_own.size(); ne = en_cyc.size();
        stub_stale = 1'b1; stub_k = 4; stub_val = 8'd33;
        post_jobs(1, 0);
        wait_done(nd + 1, ok);
        stub_stale = 1'b0;
        n_cmp++;
        if (ok !== 1'b1 || done_err[nd] !== 1'b0 || done_cand[nd] !== 8'd33 ||
            done_cyc[nd] - en_cyc[ne] !== 5) begin
            n_bad++; $display("FAIL stale_valid: got err %b cand %0d at +%0d want 0 33 +5",
                done_err[nd], done_cand[nd], done_cyc[nd] - en_cyc[ne]);
        end
    endtask

    task automatic test_reset_wait;
        int nd, ng, ne;
        bit ok;
        nd = done_own.size(); ne = en_cyc.size();
        stub_on = 1'b0;
        post_jobs(1, 0);
        for (int i = 0; i < 20 && en_cyc.size() == ne; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        n_cmp++;
        if ({r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err, set_en} !== 7'd0 ||
            {r0_candidate, r1_candidate, set_central, set_radius, set_mode} !== 54'd0) begin
            n_bad++; $display("FAIL rstwait_outputs: got %b %h",
                {r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err, set_en},
                {r0_candidate, r1_candidate, set_central, set_radius, set_mode});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (done_own.size() !== nd) begin
            n_bad++; $display("FAIL rstwait_no_done: got %0d want %0d", done_own.size(), nd);
        end
        ng = grant_own.size();
        r1_radius = 12'h0E1;
        stub_on = 1'b1; stub_echo = 1'b1; stub_k = 2;
        post_jobs(0, 1);
        wait_done(nd + 1, ok);
        n_cmp++;
        if (ok !== 1'b1 || grant_own[ng] !== 1 || done_own[nd] !== 1 ||
            done_cand[nd] !== 8'hE1 || done_err[nd] !== 1'b0) begin
            n_bad++; $display("FAIL rstwait_r1: got ok %b grant %0d own %0d cand %h err %b",
                ok, grant_own[ng], done_own[nd], done_cand[nd], done_err[nd]);
        end
    endtask

    initial begin
        test_reset;
        test_single_job;
        test_round_robin;
        test_busy_stall;
        test_timeout;
        test_collision;
        test_reset_wait;
        n_cmp++;
        if (n_err_stray !== 0) begin
            n_bad++; $display("FAIL err_without_done: got %0d want 0", n_err_stray);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
